fpcvt_seq: RTL and testbench
============================

FPCVT_SEQ -- requirements
Module: fpcvt_seq

Interface
REQ-001 Parameter W, default 12: input word width, two's complement, W >= FW+2.
REQ-002 Parameter FW, default 4: mantissa width; derived EMAX = W-1-FW, EW = clog2(EMAX+1); defaults give EMAX=7, EW=3.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  D and rnd_mode valid this cycle.
REQ-006 in_ready  out  1  block can accept; high only in IDLE.
REQ-007 D  in  W  linear two's-complement sample.
REQ-008 rnd_mode  in  2  00 truncate, 01 round-half-up, 10 round-half-even, 11 treated as 00.
REQ-009 out_valid  out  1  S/E/F/sat hold a result.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 S  out  1  sign; E  out  EW  exponent; F  out  FW  mantissa; value = F * 2^E.
REQ-012 sat  out  1  result was clamped (most-negative input or rounding overflow at EMAX).

Function
REQ-013 FSM states IDLE, NORM, DONE; transfer occurs on in_valid && in_ready.
REQ-014 On transfer: S <- D[W-1]; magnitude <- |D| over W-1 bits; D = 100..0 clamps magnitude to 2^(W-1)-1 and sets the sat flag; rnd_mode latched; exponent register <- EMAX; state -> NORM.
REQ-015 NORM, each cycle: if mag[W-2]=0 and exponent>0, shift mag left 1 (zero fill) and decrement exponent; else register result and go to DONE.
REQ-016 k = min(leading zeros of mag in W-1 bits, EMAX); out_valid rises on edge k+1 after the accepting edge.
REQ-017 Field extraction at NORM exit: F0 = mag[W-2 -: FW], round bit r = mag[W-2-FW], sticky s = OR of mag[W-3-FW:0] (0 if empty).
REQ-018 Increment: truncate never; half-up when r=1; half-even when r=1 and (s=1 or F0[0]=1).
REQ-019 Increment with F0 all ones: exponent<EMAX gives F = 2^(FW-1), E = exponent+1; exponent=EMAX gives F all ones, E=EMAX, sat=1.
REQ-020 Zero input gives S=0, E=0, F=0, sat=0 after k=EMAX.
REQ-021 DONE: out_valid=1; S/E/F/sat stable while out_ready=0; out_valid && out_ready -> IDLE, out_valid=0 next cycle.
REQ-022 in_ready=0 in NORM and DONE; in_valid ignored there; throughput one result per k+3 cycles minimum.
REQ-023 out_ready ignored while out_valid=0.

Reset
REQ-024 rst_n low at a rising edge: state IDLE, out_valid=0, S=0, E=0, F=0, sat=0, internal mag/exponent cleared.
REQ-025 Reset in NORM or DONE aborts the conversion; no result emitted; in_ready=1 in the first cycle after rst_n returns high.
REQ-026 in_ready=0 while rst_n is low.

Structure
REQ-027 Package fpcvt_pkg holds the rounding-mode enum (RND_TRUNC, RND_HALF_UP, RND_HALF_EVEN) and the FSM state typedef.
REQ-028 One combinational sub-module fpcvt_round(F0, r, s, mode, exponent -> F, E, ovf), parametrised on FW and EW; fpcvt_seq owns FSM, shifter and registers.

Verification (defaults W=12, FW=4)
REQ-029 D=0x2A0 in each mode: half-up gives S=0,E=6,F=11; half-even gives E=6,F=10; truncate gives E=6,F=10; out_valid 2 edges after accept.
REQ-030 D=0x0F8: half-up and half-even give E=5,F=8,sat=0 (mantissa carry); truncate gives E=4,F=15.
REQ-031 D=0x800, half-up -> S=1,E=7,F=15,sat=1, out_valid 1 edge after accept; D=0x005 -> S=0,E=0,F=5, out_valid 8 edges after accept.
REQ-032 Backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-033 Reset mid-NORM (D=0x005, rst_n low at edge 3) -> out_valid never rises, all outputs 0, in_ready=1 one cycle after release; the next conversion is correct.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared types for the sequential linear-to-float converter: rounding modes,
// FSM state encoding and the raw rnd_mode decode.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'b00,
        RND_HALF_UP   = 2'b01,
        RND_HALF_EVEN = 2'b10
    } rnd_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        NORM = 2'b01,
        DONE = 2'b10
    } fpcvt_state_e;

    // The unused code 2'b11 falls back to truncation.
    function automatic rnd_mode_e decode_rnd_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return RND_HALF_UP;
            2'b10:   return RND_HALF_EVEN;
            default: return RND_TRUNC;
        endcase
    endfunction

endpackage

// File: rtl/fpcvt_round.sv
// Combinational mantissa rounding: applies the selected rounding increment to
// the truncated mantissa and handles carry-out into the exponent.
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int FW   = 4,
    parameter int EW   = 3,
    parameter int EMAX = 7
) (
    input  logic [FW-1:0] f0,
    input  logic          r,
    input  logic          s,
    input  rnd_mode_e     mode,
    input  logic [EW-1:0] exp_in,
    output logic [FW-1:0] f,
    output logic [EW-1:0] e,
    output logic          ovf
);

    localparam logic [EW-1:0] EMAX_E = EW'(EMAX);

    logic inc;

    always_comb begin
        inc = 1'b0;
        case (mode)
            RND_HALF_UP:   inc = r;
            RND_HALF_EVEN: inc = r & (s | f0[0]);
            default:       inc = 1'b0;
        endcase

        f   = f0;
        e   = exp_in;
        ovf = 1'b0;
        if (inc) begin
            if (&f0) begin
                // Mantissa carry: renormalise into the next exponent, or clamp at the top.
                if (exp_in == EMAX_E) begin
                    f   = '1;
                    ovf = 1'b1;
                end else begin
                    f = FW'(1) << (FW - 1);
                    e = exp_in + 1'b1;
                end
            end else begin
                f = f0 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to sign/exponent/mantissa converter: one-bit-per-cycle
// normaliser feeding a rounding stage, with valid/ready on both sides.
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter int W  = 12,
    parameter int FW = 4,
    localparam int EMAX = W - 1 - FW,
    localparam int EW   = $clog2(EMAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  D,
    input  logic [1:0]    rnd_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [FW-1:0] F,
    output logic          sat,
    output fpcvt_state_e  state_dbg
);

    // Handshakes: a word moves on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE (and never during reset); out_valid is high
    // exactly in DONE, where the result holds steady until out_ready is seen.

    localparam logic [EW-1:0] EMAX_E = EW'(EMAX);

    fpcvt_state_e  state_q, state_d;
    logic [W-2:0]  mag_q, mag_d;
    logic [EW-1:0] exp_q, exp_d;
    rnd_mode_e     mode_q, mode_d;
    logic          clamp_q, clamp_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] e_q, e_d;
    logic [FW-1:0] f_q, f_d;
    logic          sat_q, sat_d;

    logic [W-2:0]  abs_mag;
    logic          is_min;
    logic          sticky;
    logic [FW-1:0] rnd_f;
    logic [EW-1:0] rnd_e;
    logic          rnd_ovf;

    // Low W-1 bits of -D are ~D+1 on those bits alone; the most-negative word wraps to 0.
    assign is_min  = D[W-1] && (D[W-2:0] == '0);
    assign abs_mag = D[W-1] ? (~D[W-2:0] + 1'b1) : D[W-2:0];

    generate
        if (W - 3 - FW >= 0) begin : g_sticky
            assign sticky = |mag_q[W-3-FW:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

    fpcvt_round #(
        .FW   (FW),
        .EW   (EW),
        .EMAX (EMAX)
    ) u_round (
        .f0     (mag_q[W-2 -: FW]),
        .r      (mag_q[W-2-FW]),
        .s      (sticky),
        .mode   (mode_q),
        .exp_in (exp_q),
        .f      (rnd_f),
        .e      (rnd_e),
        .ovf    (rnd_ovf)
    );

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        mode_d  = mode_q;
        clamp_d = clamp_q;
        sign_d  = sign_q;
        e_d     = e_q;
        f_d     = f_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = D[W-1];
                    mag_d   = is_min ? '1 : abs_mag;
                    clamp_d = is_min;
                    mode_d  = decode_rnd_mode(rnd_mode);
                    exp_d   = EMAX_E;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (!mag_q[W-2] && (exp_q != '0)) begin
                    mag_d = {mag_q[W-3:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end else begin
                    e_d     = rnd_e;
                    f_d     = rnd_f;
                    sat_d   = clamp_q | rnd_ovf;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            mode_q  <= RND_TRUNC;
            clamp_q <= 1'b0;
            sign_q  <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            mode_q  <= mode_d;
            clamp_q <= clamp_d;
            sign_q  <= sign_d;
            e_q     <= e_d;
            f_q     <= f_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = sign_q;
    assign E         = e_q;
    assign F         = f_q;
    assign sat       = sat_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fpcvt_seq.sv
// Bench for fpcvt_seq: arithmetic reference model feeds an expected queue,
// a negedge monitor pops and compares every result and its latency.
module tb_fpcvt_seq;
  import fpcvt_pkg::*;

  localparam int W    = 12;
  localparam int FW   = 4;
  localparam int EMAX = 7;
  localparam int EW   = 3;
  localparam int RW   = 1 + EW + FW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  D = '0;
  logic [1:0]    rnd_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          S;
  logic [EW-1:0] E;
  logic [FW-1:0] F;
  logic          sat;
  fpcvt_state_e  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  int cyc = 0;
  int accept_edge = 0;
  logic last_ov = 1'b0;
  bit rand_ready = 1'b0;

  fpcvt_seq #(.W(W), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .sat       (sat),
    .state_dbg (state_dbg)
  );

  // clock / reset-independent bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: exponent from the position of the leading one, mantissa by division,
  // rounding decided from the discarded remainder against half an output LSB.
  function automatic void model(input logic [W-1:0] d, input logic [1:0] m,
                                output logic [RW-1:0] res, output int lat);
    int mag, p, e0, f0, rem, half, f, e;
    bit inc, sgn, sflag;
    sgn   = d[W-1];
    sflag = 1'b0;
    mag   = sgn ? (1 << W) - int'(d) : int'(d);
    if (mag > (1 << (W-1)) - 1) begin
      mag   = (1 << (W-1)) - 1;
      sflag = 1'b1;
    end
    p = -1;
    for (int i = 0; i < W-1; i++) if (((mag >> i) & 1) == 1) p = i;
    if (p < 0) begin
      lat = EMAX + 1;
      e0  = 0;
    end else begin
      lat = (((W-2-p) < EMAX) ? (W-2-p) : EMAX) + 1;
      e0  = (p - (FW-1) > 0) ? p - (FW-1) : 0;
    end
    f0   = mag >> e0;
    rem  = mag - (f0 << e0);
    half = (e0 > 0) ? (1 << (e0-1)) : 0;
    inc  = 1'b0;
    if (e0 > 0) begin
      case (m)
        2'b01:   inc = (rem >= half);
        2'b10:   inc = (rem > half) || (rem == half && (f0 % 2) == 1);
        default: inc = 1'b0;
      endcase
    end
    f = f0;
    e = e0;
    if (inc) begin
      f = f0 + 1;
      if (f == (1 << FW)) begin
        if (e0 < EMAX) begin
          f = 1 << (FW-1);
          e = e0 + 1;
        end else begin
          f = (1 << FW) - 1;
          sflag = 1'b1;
        end
      end
    end
    res = {sgn, e[EW-1:0], f[FW-1:0], sflag};
  endfunction

  // scoreboard monitor
  initial begin
    logic [RW-1:0] ex;
    int el;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_ov = 1'b0;
      end else begin
        if (out_valid && !last_ov) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got S=%0d E=%0d F=%0d sat=%0d required none", S, E, F, sat);
          end else begin
            ex = exp_q.pop_front();
            el = lat_q.pop_front();
            check("result", 32'({S, E, F, sat}), 32'(ex));
            check("latency", cyc - accept_edge, el);
          end
        end
        last_ov = out_valid;
        if (in_valid && in_ready) accept_edge = cyc + 1;
      end
    end
  end

  // random consumer
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] m, input bit push);
    logic [RW-1:0] r;
    int l;
    int n;
    model(d, m, r, l);
    @(posedge clk);
    #1;
    D = d;
    rnd_mode = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 required 1");
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(r);
      lat_q.push_back(l);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  logic [W-1:0] dir_d[13]  = '{12'h2A0, 12'h2A0, 12'h2A0, 12'h0F8, 12'h0F8, 12'h0F8, 12'h800,
                               12'h005, 12'h000, 12'h7FF, 12'hFFF, 12'h2A0, 12'h801};
  logic [1:0]   dir_m[13]  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01,
                               2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10};

  initial begin
    logic [RW-1:0] bp_exp;
    int bp_lat;
    int n;
    bit seen;
    logic [W-1:0] rd;

    // reset: in_valid asserted but must be ignored
    rst_n = 1'b0;
    in_valid = 1'b1;
    D = 12'h123;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({S, E, F, sat}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed patterns
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(dir_d[i], dir_m[i], 1'b1);
      wait_drain(50);
    end

    // backpressure
    out_ready = 1'b0;
    model(12'h2A0, 2'b01, bp_exp, bp_lat);
    send(12'h2A0, 2'b01, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      D = W'($urandom);
      in_valid = (i % 2 == 0);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'({S, E, F, sat}), 32'(bp_exp));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // reset mid-NORM aborts the conversion
    @(posedge clk);
    #1;
    D = 12'h005;
    rnd_mode = 2'b01;
    in_valid = 1'b1;
    check("abort_pre_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_outputs", 32'({S, E, F, sat}), 32'd0);
    check("abort_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready_high", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    send(12'h005, 2'b01, 1'b1);
    wait_drain(50);

    // randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) rd = W'($urandom_range(0, 31));
      else rd = W'($urandom);
      send(rd, 2'($urandom_range(0, 3)), 1'b1);
    end
    wait_drain(300);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
